// File: rtl/bitstream_unpacker_512_pkg.sv
// Shared constants, state encoding and helpers for the 512-bit bitstream unpacker.
package bitstream_unpacker_512_pkg;

    localparam int WORD_W     = 512;
    localparam int BUF_W      = 1024;
    localparam int PTR_W      = 10;
    localparam int CNT_W      = 11;
    localparam int LAST_LEN_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Bits contributed by an accepted word: a full word, or the short tail of the stream.
    function automatic logic [CNT_W-1:0] word_bits(input logic                  last,
                                                   input logic [LAST_LEN_W-1:0] last_len);
        return last ? CNT_W'(last_len) : CNT_W'(WORD_W);
    endfunction

endpackage

// File: rtl/bitstream_unpacker_512_bit_window_extract.sv
// Combinational extractor: WIN_W bits of the circular buffer starting at rd_ptr_i,
// wrapping from bit BUF_W-1 back to bit 0.
module bit_window_extract
    import bitstream_unpacker_512_pkg::*;
#(
    parameter int WIN_W = 32
) (
    input  logic [BUF_W-1:0] data_i,
    input  logic [PTR_W-1:0] rd_ptr_i,
    output logic [WIN_W-1:0] window_o
);

    always_comb begin
        window_o = '0;
        for (int i = 0; i < WIN_W; i++) begin
            // PTR_W-bit sum wraps modulo the buffer size by construction.
            window_o[i] = data_i[rd_ptr_i + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/bitstream_unpacker_512.sv
// Two-slot (1024-bit) circular unpacker presenting an LSB-first bit window to a
// variable-rate decoder. Define UNPACK_ERR_CHECK_EN to flag and clamp over-consumes.
module bitstream_unpacker_512
    import bitstream_unpacker_512_pkg::*;
#(
    parameter int WIN_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [LAST_LEN_W-1:0]   in_last_len,
    output logic [WIN_W-1:0]        out_window,
    output logic [CNT_W-1:0]        out_avail,
    input  logic                    consume_en,
    input  logic [$clog2(WIN_W):0]  consume_len,
    output logic                    out_done,
    output logic                    err
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_slot_q, wr_slot_d;
    logic [1:0]       slots_used_q, slots_used_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BUF_W-1:0] mem_q;
    logic [WIN_W-1:0] raw_window;
    logic             accept;
    logic             slot_free;
    logic [CNT_W-1:0] add_len, req_len, take_len;

    assign in_ready = !rst && (slots_used_q < 2'd2) && (state_q inside {IDLE, STREAM});
    assign accept   = in_valid && in_ready;
    assign add_len  = accept ? word_bits(in_last, in_last_len) : '0;
    assign req_len  = consume_en ? CNT_W'(consume_len) : '0;

`ifdef UNPACK_ERR_CHECK_EN
    logic over;
    logic err_q;

    assign over     = req_len > count_q;
    assign take_len = over ? count_q : req_len;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst)       err_q <= 1'b0;
        else if (over) err_q <= 1'b1;
    end
`else
    assign take_len = req_len;
    assign err      = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q + PTR_W'(take_len);
        count_d      = count_q + add_len - take_len;
        wr_slot_d    = wr_slot_q ^ accept;
        // A slot frees when the read pointer leaves it, or when a short final word empties.
        slot_free    = (rd_ptr_d[PTR_W-1] != rd_ptr_q[PTR_W-1]) ||
                       ((count_d == '0) && (count_q != '0));
        slots_used_d = slots_used_q + {1'b0, accept} - {1'b0, slot_free};

        unique case (state_q)
            IDLE:   if (accept) state_d = in_last ? DRAIN : STREAM;
            STREAM: if (accept && in_last) state_d = DRAIN;
            DRAIN:  if (count_d == '0) state_d = DONE;
            DONE: begin
                state_d      = IDLE;
                rd_ptr_d     = '0;
                count_d      = '0;
                wr_slot_d    = 1'b0;
                slots_used_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_slot_q    <= 1'b0;
            slots_used_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_slot_q    <= wr_slot_d;
            slots_used_q <= slots_used_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the data buffer has no reset; bits beyond out_avail are masked off below.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_slot_q) mem_q[BUF_W-1:WORD_W] <= in_data;
            else           mem_q[WORD_W-1:0]     <= in_data;
        end
    end

    bit_window_extract #(
        .WIN_W    (WIN_W)
    ) u_extract (
        .data_i   (mem_q),
        .rd_ptr_i (rd_ptr_q),
        .window_o (raw_window)
    );

    always_comb begin
        out_window = '0;
        for (int i = 0; i < WIN_W; i++) begin
            out_window[i] = raw_window[i] && (CNT_W'(i) < count_q);
        end
    end

    assign out_avail = count_q;
    assign out_done  = (state_q == DONE);

endmodule

// File: tb/tb_bitstream_unpacker_512.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a bit-queue reference model of the stream.
module tb_bitstream_unpacker_512;
    import bitstream_unpacker_512_pkg::*;

    localparam int WIN_W = 32;
    localparam int CL_W  = $clog2(WIN_W) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic [8:0]        in_last_len = '0;
    logic [WIN_W-1:0]  out_window;
    logic [CNT_W-1:0]  out_avail;
    logic              consume_en = 1'b0;
    logic [CL_W-1:0]   consume_len = '0;
    logic              out_done;
    logic              err;

    bitstream_unpacker_512 #(.WIN_W(WIN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_last_len (in_last_len),
        .out_window  (out_window),
        .out_avail   (out_avail),
        .consume_en  (consume_en),
        .consume_len (consume_len),
        .out_done    (out_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: the buffered stream as a queue of bits, earliest first.
    bit m_bits[$];
    int m_ends[$];
    int m_consumed;
    int m_pushed;
    bit m_last;
    bit m_done;
    bit m_err;

    function automatic void model_clear_stream();
        m_bits.delete();
        m_ends.delete();
        m_consumed = 0;
        m_pushed   = 0;
        m_last     = 1'b0;
        m_done     = 1'b0;
    endfunction

    function automatic bit model_ready();
        return !m_last && !m_done && (m_ends.size() < 2);
    endfunction

    function automatic logic [WIN_W-1:0] model_window();
        logic [WIN_W-1:0] w = '0;
        for (int i = 0; i < WIN_W; i++) if (i < m_bits.size()) w[i] = m_bits[i];
        return w;
    endfunction

    function automatic int model_avail();
        return m_bits.size();
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".avail"},  out_avail,  model_avail());
        check({tag, ".window"}, out_window, model_window());
        check({tag, ".ready"},  in_ready,   model_ready());
        check({tag, ".done"},   out_done,   m_done);
        check({tag, ".err"},    err,        m_err);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare.
    task automatic step(input string tag, input bit v, input logic [WORD_W-1:0] d,
                        input bit l, input int ll, input bit ce, input int cl);
        bit acc;
        bit was_last;
        int take;
        int n;
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        in_last_len = ll[8:0];
        consume_en  = ce;
        consume_len = cl[CL_W-1:0];
        acc = v && model_ready();
        @(posedge clk);
        #1;
        take = ce ? cl : 0;
        if (take > m_bits.size()) begin
`ifdef UNPACK_ERR_CHECK_EN
            m_err = 1'b1;
`endif
            take = m_bits.size();
        end
        repeat (take) void'(m_bits.pop_front());
        m_consumed += take;
        while (m_ends.size() > 0 && m_ends[0] <= m_consumed) void'(m_ends.pop_front());
        if (acc) begin
            n = l ? ll : WORD_W;
            for (int i = 0; i < n; i++) m_bits.push_back(d[i]);
            m_pushed += n;
            m_ends.push_back(m_pushed);
        end
        was_last = m_last;
        if (m_done) model_clear_stream();
        else m_done = was_last && (m_bits.size() == 0);
        if (acc && l) m_last = 1'b1;
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic take_bits(input string tag, input int n);
        step(tag, 1'b0, '0, 1'b0, 0, 1'b1, n);
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        in_valid   = 1'b0;
        consume_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".rst_ready"},  in_ready,   1'b0);
        check({tag, ".rst_avail"},  out_avail,  '0);
        check({tag, ".rst_window"}, out_window, '0);
        check({tag, ".rst_done"},   out_done,   1'b0);
        check({tag, ".rst_err"},    err,        1'b0);
        rst = 1'b0;
        model_clear_stream();
        m_err = 1'b0;
        #1;
        check({tag, ".ready_after_rst"}, in_ready, 1'b1);
    endtask

    logic [WORD_W-1:0] w0, w1, w2;
    logic [WIN_W-1:0]  exp_win;

    initial begin
        model_clear_stream();
        m_err = 1'b0;

        // Short stream: one full word then a 100-bit tail, drained 32 bits per cycle.
        do_reset("t1");
        w0 = rand_word();
        w0[7:0] = 8'hA5;
        step("t1.acc0", 1'b1, w0, 1'b0, 0, 1'b0, 0);
        check("t1.win_a5", out_window[7:0], 8'hA5);
        step("t1.acc1", 1'b1, rand_word(), 1'b1, 100, 1'b0, 0);
        check("t1.avail612", out_avail, 11'd612);
        for (int i = 0; i < 20; i++) take_bits("t1.cons", (model_avail() < 32) ? model_avail() : 32);
        check("t1.done_after_20", out_done, 1'b1);
        idle("t1.post");

        // Both slots full, then free one, then read across the 1023 -> 0 wrap.
        do_reset("t2");
        w0 = rand_word();
        w1 = rand_word();
        w2 = rand_word();
        step("t2.acc0", 1'b1, w0, 1'b0, 0, 1'b0, 0);
        step("t2.acc1", 1'b1, w1, 1'b0, 0, 1'b0, 0);
        check("t2.full_ready", in_ready, 1'b0);
        check("t2.full_avail", out_avail, 11'd1024);
        for (int i = 0; i < 16; i++) take_bits("t2.cons", 32);
        check("t2.ready_again", in_ready, 1'b1);
        step("t2.acc2", 1'b1, w2, 1'b0, 0, 1'b1, 32);
        for (int i = 0; i < 14; i++) take_bits("t3.cons", 32);
        take_bits("t3.cons18", 18);
        exp_win[13:0]  = w1[511:498];
        exp_win[31:14] = w2[17:0];
        check("t3.wrap_window", out_window, exp_win);
        take_bits("t3.cons_wrap", 32);

        // Simultaneous accept and consume.
        do_reset("t4");
        step("t4.acc0", 1'b1, rand_word(), 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 14; i++) take_bits("t4.cons", 32);
        take_bits("t4.cons24", 24);
        check("t4.avail40", out_avail, 11'd40);
        step("t4.acc_cons", 1'b1, rand_word(), 1'b0, 0, 1'b1, 20);
        check("t4.avail532", out_avail, 11'd532);

        // Zero-length final word arriving while empty.
        do_reset("t5");
        step("t5.acc", 1'b1, rand_word(), 1'b1, 0, 1'b0, 0);
        check("t5.no_done_yet", out_done, 1'b0);
        idle("t5.wait");
        check("t5.done_pulse", out_done, 1'b1);
        check("t5.avail0", out_avail, '0);
        idle("t5.post");
        check("t5.done_cleared", out_done, 1'b0);

        // Reset with 700 bits buffered.
        do_reset("t6");
        step("t6.acc0", 1'b1, rand_word(), 1'b0, 0, 1'b0, 0);
        step("t6.acc1", 1'b1, rand_word(), 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 10; i++) take_bits("t6.cons", 32);
        take_bits("t6.cons4", 4);
        check("t6.avail700", out_avail, 11'd700);
        do_reset("t6.mid");
        for (int i = 0; i < 3; i++) idle("t6.after");

`ifdef UNPACK_ERR_CHECK_EN
        // Over-consume is flagged and clamped, and the drain still completes.
        do_reset("t7");
        step("t7.acc", 1'b1, rand_word(), 1'b1, 10, 1'b0, 0);
        take_bits("t7.over", 32);
        check("t7.err", err, 1'b1);
        check("t7.avail0", out_avail, '0);
        idle("t7.done");
        check("t7.done_pulse", out_done, 1'b1);
        idle("t7.post");
`endif

        // Random traffic: random arrivals, random legal consume sizes, occasional stream ends.
        do_reset("rnd");
        for (int c = 0; c < 3000; c++) begin
            int lim;
            lim = (model_avail() < WIN_W) ? model_avail() : WIN_W;
            step("rnd", $urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 511), $urandom_range(0, 4) != 0, $urandom_range(0, lim));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
